// File: rtl/alu_pkg.sv
// Shared types and constants for the R-type issue stage: instruction field
// layout, issue-register contents and the set of legal ALU funct codes.
package alu_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } r_inst_t;

  typedef struct packed {
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rd;
  } issue_t;

  // Only SPECIAL-opcode words with an ALU funct the datapath implements.
  function automatic logic is_legal(input r_inst_t i);
    if (i.op != OP_SPECIAL) return 1'b0;
    case (i.funct)
      F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLL, F_SRL, F_SRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational read ports, one write port,
// register 0 hardwired to zero, whole array cleared on reset.
module alu_regfile #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] rda,
  output logic [31:0] rdb,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [NREG-1:0][31:0] mem;

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mem <= '0;
    else if (we && wa != '0) mem[wa] <= wd;
  end

  assign rda = (ra == '0) ? '0 : mem[ra];
  assign rdb = (rb == '0) ? '0 : mem[rb];

endmodule

// File: rtl/alu_issue.sv
// R-type issue stage: decode, scoreboard interlock, operand read and the
// registered issue slot feeding the ALU. Define ALU_ISSUE_BYPASS_EN to let a
// source being written back this cycle issue with the writeback data.
module alu_issue
  import alu_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [31:0] iss_rs_val,
  output logic [31:0] iss_rt_val,
  output logic [5:0]  iss_funct,
  output logic [4:0]  iss_shamt,
  output logic [4:0]  iss_rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        illegal
);

  r_inst_t        f;
  logic           legal, hazard, accept;
  logic           rs_busy, rt_busy;
  logic [31:0]    rf_a, rf_b, rs_v, rt_v;
  logic [NREG-1:0] sb, sb_nxt;
  issue_t         iss_q;
  logic           iss_v_q, illegal_q;

  assign f     = inst;
  assign legal = is_legal(f);

  alu_regfile #(.NREG(NREG)) u_rf (
    .clk  (clk),
    .rstn (rstn),
    .ra   (f.rs),
    .rb   (f.rt),
    .rda  (rf_a),
    .rdb  (rf_b),
    .we   (wb_en),
    .wa   (wb_addr),
    .wd   (wb_data)
  );

`ifdef ALU_ISSUE_BYPASS_EN
  logic byp_rs, byp_rt;
  assign byp_rs  = wb_en && (wb_addr != '0) && (wb_addr == f.rs);
  assign byp_rt  = wb_en && (wb_addr != '0) && (wb_addr == f.rt);
  assign rs_v    = byp_rs ? wb_data : rf_a;
  assign rt_v    = byp_rt ? wb_data : rf_b;
  assign rs_busy = sb[f.rs] && !byp_rs;
  assign rt_busy = sb[f.rt] && !byp_rt;
`else
  assign rs_v    = rf_a;
  assign rt_v    = rf_b;
  assign rs_busy = sb[f.rs];
  assign rt_busy = sb[f.rt];
`endif

  // Illegal words are dropped, so they must never wait on the scoreboard.
  assign hazard     = legal && (rs_busy || rt_busy || sb[f.rd]);
  assign inst_ready = (!iss_v_q || iss_ready) && !hazard;
  assign accept     = inst_valid && inst_ready;

  // Writeback clears first so a same-cycle issue to that register re-sets it.
  always_comb begin
    sb_nxt = sb;
    if (wb_en && wb_addr != '0) sb_nxt[wb_addr] = 1'b0;
    if (accept && legal && f.rd != '0) sb_nxt[f.rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      iss_v_q   <= 1'b0;
      iss_q     <= '0;
      illegal_q <= 1'b0;
      sb        <= '0;
    end else begin
      illegal_q <= accept && !legal;
      sb        <= sb_nxt;
      if (accept && legal) begin
        iss_v_q <= 1'b1;
        iss_q   <= '{rs_val: rs_v, rt_val: rt_v, funct: f.funct,
                     shamt: f.shamt, rd: f.rd};
      end else if (iss_v_q && iss_ready) begin
        iss_v_q <= 1'b0;
      end
    end
  end

  assign iss_valid  = iss_v_q;
  assign iss_rs_val = iss_q.rs_val;
  assign iss_rt_val = iss_q.rt_val;
  assign iss_funct  = iss_q.funct;
  assign iss_shamt  = iss_q.shamt;
  assign iss_rd     = iss_q.rd;
  assign illegal    = illegal_q;

endmodule
